// File: rtl/simon64_96_seq_if.sv
// Handshake bundle for the SIMON64/96 sequencer:
// key load, block in, result out, status.
interface simon64_96_seq_if;
  logic        key_valid;
  logic        key_ready;
  logic [95:0] key;
  logic        in_valid;
  logic        in_ready;
  logic        encrypt_or_decrypt;
  logic [63:0] in_text;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_text;
  logic        key_loaded;
  logic        busy;

  modport master (
    output key_valid, key, in_valid,
    output encrypt_or_decrypt, in_text, out_ready,
    input  key_ready, in_ready, out_valid,
    input  out_text, key_loaded, busy
  );

  modport slave (
    input  key_valid, key, in_valid,
    input  encrypt_or_decrypt, in_text, out_ready,
    output key_ready, in_ready, out_valid,
    output out_text, key_loaded, busy
  );
endinterface

// File: rtl/simon64_96_seq.sv
// SIMON64/96 iterative sequencer, UNROLL rounds/clk.
// SIMON_KEY_CACHE_EN: keep all 42 keys, else regenerate.
module simon64_96_seq #(
  parameter int UNROLL = 1
) (
  input logic clk,
  input logic rst,
  simon64_96_seq_if.slave bus
);
  localparam logic [63:0] Z = 64'h7369f885192c0ef5;
  localparam logic [31:0] C = 32'hfffffffc;
  localparam logic [5:0] U6 = 6'(UNROLL);
  localparam logic [5:0] LAST_E = 6'(42 - UNROLL);
  localparam logic [5:0] LAST_D = 6'(UNROLL - 1);

  typedef enum logic [1:0] {
    IDLE, EXPAND, RUN, DONE
  } state_t;

  state_t r_state, w_next;

  function automatic logic [31:0] f_rnd(
    input logic [31:0] v
  );
    return ({v[30:0], v[31]} & {v[23:0], v[31:24]})
         ^ {v[29:0], v[31:30]};
  endfunction

  function automatic logic [31:0] t_ks(
    input logic [31:0] v
  );
    logic [31:0] s;
    s = {v[2:0], v[31:3]};
    return s ^ {s[0], s[31:1]};
  endfunction

  function automatic logic [63:0] rnd(
    input logic [63:0] xy,
    input logic [31:0] k,
    input logic        enc
  );
    logic [31:0] x, y;
    x = xy[63:32];
    y = xy[31:0];
    if (enc) return {y ^ f_rnd(x) ^ k, x};
    else     return {y, x ^ f_rnd(y) ^ k};
  endfunction

  logic [5:0]  r_ectr, r_rc;
  logic        r_loaded, r_enc;
  logic [31:0] r_x, r_y;
  logic [31:0] r_w0, r_w1, r_w2;
  logic [63:0] r_out;
  logic [31:0] w_knew;
  logic [63:0] w_xy;
  logic [5:0]  w_idx;
  logic        w_key_hs, w_in_hs, w_last;

`ifdef SIMON_KEY_CACHE_EN
  logic [31:0] r_ks [42];
`else
  logic [31:0] r_b0, r_b1, r_b2;
  logic [31:0] r_ka, r_kb, r_kc;
  logic [31:0] w_ka, w_kb, w_kc, w_kn;
`endif

  assign w_key_hs = bus.key_valid && (r_state == IDLE);
  assign w_in_hs  = bus.in_valid && bus.in_ready;
  assign w_last   = r_enc ? (r_rc == LAST_E)
                          : (r_rc == LAST_D);
  assign w_knew   = C ^ {31'd0, Z[r_ectr - 6'd3]}
                  ^ r_w0 ^ t_ks(r_w2);
  assign bus.out_text   = r_out;
  assign bus.key_loaded = r_loaded;

  always_comb begin
    w_next        = r_state;
    bus.key_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        bus.key_ready = 1'b1;
        bus.busy      = 1'b0;
        // a pending key always wins over a block
        bus.in_ready  = r_loaded && !bus.key_valid;
        if (bus.key_valid) w_next = EXPAND;
        else if (bus.in_valid && r_loaded) w_next = RUN;
      end
      EXPAND: if (r_ectr == 6'd41) w_next = IDLE;
      RUN:    if (w_last) w_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_xy  = {r_x, r_y};
    w_idx = r_rc;
`ifndef SIMON_KEY_CACHE_EN
    w_ka = r_ka;
    w_kb = r_kb;
    w_kc = r_kc;
    w_kn = '0;
`endif
    for (int u = 0; u < UNROLL; u++) begin
      w_idx = r_enc ? r_rc + 6'(u) : r_rc - 6'(u);
`ifdef SIMON_KEY_CACHE_EN
      w_xy = rnd(w_xy,
        (w_idx < 6'd42) ? r_ks[w_idx] : '0, r_enc);
`else
      w_xy = rnd(w_xy, w_ka, r_enc);
      // window: enc (k[i],k[i+1],k[i+2]), dec (k[i],k[i-1],k[i-2])
      w_kn = r_enc
        ? C ^ {31'd0, Z[w_idx]} ^ w_ka ^ t_ks(w_kc)
        : C ^ {31'd0, Z[w_idx - 6'd3]} ^ w_ka ^ t_ks(w_kb);
      w_ka = w_kb;
      w_kb = w_kc;
      w_kc = w_kn;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_loaded <= 1'b0;
      r_ectr   <= 6'd3;
      r_rc     <= '0;
      r_enc    <= 1'b1;
      r_x      <= '0;
      r_y      <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_key_hs) begin
            r_loaded <= 1'b0;
            r_ectr   <= 6'd3;
          end else if (w_in_hs) begin
            r_x   <= bus.in_text[63:32];
            r_y   <= bus.in_text[31:0];
            r_enc <= bus.encrypt_or_decrypt;
            r_rc  <= bus.encrypt_or_decrypt
                     ? 6'd0 : 6'd41;
          end
        end
        EXPAND: begin
          if (r_ectr == 6'd41) r_loaded <= 1'b1;
          else r_ectr <= r_ectr + 6'd1;
        end
        RUN: begin
          {r_x, r_y} <= w_xy;
          if (w_last) r_out <= w_xy;
          else r_rc <= r_enc ? r_rc + U6 : r_rc - U6;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_key_hs) begin
      r_w0 <= bus.key[31:0];
      r_w1 <= bus.key[63:32];
      r_w2 <= bus.key[95:64];
`ifdef SIMON_KEY_CACHE_EN
      r_ks[0] <= bus.key[31:0];
      r_ks[1] <= bus.key[63:32];
      r_ks[2] <= bus.key[95:64];
`else
      r_b0 <= bus.key[31:0];
      r_b1 <= bus.key[63:32];
      r_b2 <= bus.key[95:64];
`endif
    end else if (r_state == EXPAND) begin
      r_w0 <= r_w1;
      r_w1 <= r_w2;
      r_w2 <= w_knew;
`ifdef SIMON_KEY_CACHE_EN
      r_ks[r_ectr] <= w_knew;
`endif
    end
`ifndef SIMON_KEY_CACHE_EN
    else if (w_in_hs) begin
      r_ka <= bus.encrypt_or_decrypt ? r_b0 : r_w2;
      r_kb <= bus.encrypt_or_decrypt ? r_b1 : r_w1;
      r_kc <= bus.encrypt_or_decrypt ? r_b2 : r_w0;
    end else if (r_state == RUN) begin
      r_ka <= w_ka;
      r_kb <= w_kb;
      r_kc <= w_kc;
    end
`endif
  end
endmodule
